// File: rtl/pulse_stretch_mc_pkg.sv
// Shared definitions for the multi-channel pulse stretcher:
// per-channel FSM state encoding and the sizing helper for the
// shared HIGH/GAP down-counter.
package pulse_stretch_mc_pkg;

    // Per-channel stretcher state, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_GAP  = 2'b10
    } ps_state_e;

    // One counter times both HIGH and GAP phases, so it must hold
    // max(HIGH_CYCLES, GAP_CYCLES)-1. A 1-bit floor keeps the vector
    // legal when both phases are a single cycle.
    function automatic int cnt_width(input int high_cycles, input int gap_cycles);
        int longest;
        longest = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// Single channel of the pulse stretcher: IDLE/HIGH/GAP FSM with a
// shared down-counter, a saturating pending-event counter that queues
// events arriving while busy, and a sticky overflow flag for events
// lost to saturation. All outputs are registered.
module pulse_stretch_ch
    import pulse_stretch_mc_pkg::*;
#(
    parameter int HIGH_CYCLES = 3,
    parameter int GAP_CYCLES  = 3,
    parameter int PEND_W      = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    input  logic ovf_clr,
    output logic pulse_out,
    output logic busy,
    output logic overflow
);

    localparam int                CNT_W     = cnt_width(HIGH_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    ps_state_e         state;
    ps_state_e         state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_next;
    logic              pend_inc;
    logic              pend_dec;
    logic              drop;

    // Next-state and counter logic; also decides whether this cycle's
    // event is queued (pend_inc) or a queued event is replayed (pend_dec).
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        pend_inc   = pulse_in;
        pend_dec   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pulse_in) begin
                    // Event is consumed directly by starting a pulse.
                    state_next = ST_HIGH;
                    cnt_next   = HIGH_LOAD;
                    pend_inc   = 1'b0;
                end
            end

            ST_HIGH: begin
                if (cnt == '0) begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            ST_GAP: begin
                if (cnt == '0) begin
                    if (pend != '0) begin
                        // Replay the oldest queued event; a coincident new
                        // event is queued in its place (net change zero).
                        state_next = ST_HIGH;
                        cnt_next   = HIGH_LOAD;
                        pend_dec   = 1'b1;
                    end else if (pulse_in) begin
                        // Event in the last gap cycle starts without extension.
                        state_next = ST_HIGH;
                        cnt_next   = HIGH_LOAD;
                        pend_inc   = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Saturating pending counter; an increment into a full counter is a drop.
    always_comb begin
        pend_next = pend;
        drop      = 1'b0;
        if (pend_inc && !pend_dec) begin
            if (pend == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pend_next = pend + PEND_ONE;
            end
        end else if (pend_dec && !pend_inc) begin
            pend_next = pend - PEND_ONE;
        end
    end

    // State, counters and registered outputs; reset truncates any pulse in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pend      <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the same pre-edge values, independent of statement order.
            state     <= state_next;
            cnt       <= cnt_next;
            pend      <= pend_next;
            pulse_out <= (state_next == ST_HIGH);
            busy      <= (state_next != ST_IDLE) || (pend_next != '0);
            // A drop in the same cycle as a clear keeps the flag set.
            overflow  <= (overflow & ~ovf_clr) | drop;
        end
    end

endmodule

// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher: CHANNELS fully independent
// pulse_stretch_ch instances sharing only clock and reset.
module pulse_stretch_mc #(
    parameter int CHANNELS    = 4,
    parameter int HIGH_CYCLES = 3,
    parameter int GAP_CYCLES  = 3,
    parameter int PEND_W      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] pulse_in,
    input  logic [CHANNELS-1:0] ovf_clr,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] overflow
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_stretch_ch #(
            .HIGH_CYCLES (HIGH_CYCLES),
            .GAP_CYCLES  (GAP_CYCLES),
            .PEND_W      (PEND_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .pulse_in  (pulse_in[i]),
            .ovf_clr   (ovf_clr[i]),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .overflow  (overflow[i])
        );
    end

endmodule
